// File: rtl/led_counter.sv
// led_counter: counts rising edges of blink onto a WIDTH-bit LED bank, with debounced direction and pause buttons.
// Ports: clk, rst_n (async active-low) | blink (clk-synchronous slow level) | btn_dir, btn_pause (raw async buttons)
//        leds (count) | dir (1 = down) | paused (1 = frozen) | tick (pulse in the first cycle leds shows a new value)
module led_counter #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int WRAP            = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blink,
   input  logic             btn_dir,
   input  logic             btn_pause,
   output logic [WIDTH-1:0] leds,
   output logic             dir,
   output logic             paused,
   output logic             tick
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   typedef enum logic [1:0] {RUN_UP = 2'b00, HOLD_UP = 2'b01, RUN_DOWN = 2'b10, HOLD_DOWN = 2'b11} state_t;
   state_t state;
   logic [1:0] btn, press;
   logic blink_q, step, at_lim, adv;
   logic [WIDTH-1:0] nxt;
   assign btn = {btn_pause, btn_dir};
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic s1, s2, db;
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
         end else begin
            s1 <= btn[b];
            s2 <= s1;
            if (s2 == db) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               db  <= s2;
               cnt <= '0;
            end else cnt <= cnt + CW'(1);
         end
      // press fires on the same edge the debounced level rises
      assign press[b] = s2 & ~db & (cnt == CW'(DEBOUNCE_CYCLES - 1));
   end
   assign step   = blink & ~blink_q;
   assign at_lim = state[1] ? (leds == '0) : (leds == '1);
   assign nxt    = state[1] ? leds - WIDTH'(1) : leds + WIDTH'(1);
   // saturating mode suppresses the step at a limit, so no tick either
   assign adv    = step & ~state[0] & ((WRAP != 0) | ~at_lim);
   assign dir    = state[1];
   assign paused = state[0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         blink_q <= 1'b1;
         leds    <= '0;
         tick    <= 1'b0;
         state   <= RUN_UP;
      end else begin
         blink_q <= blink;
         tick    <= adv;
         if (adv) leds <= nxt;
         state <= state_t'(state ^ {press[0], press[1]});
      end
endmodule
